// File: rtl/exec_stage_pipe.sv
// Y86 execute stage: operand select, ALU, clocked condition codes, branch/cmov
// condition, and a single-entry E->M pipeline register with valid/ready handshake.
module exec_stage_pipe #(
  parameter int         WIDTH  = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic [3:0]       dstE,
  input  logic             m_stat_bad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic             out_cnd,
  output logic [2:0]       cc
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    F_ADD = 4'h0,
    F_SUB = 4'h1,
    F_AND = 4'h2,
    F_XOR = 4'h3
  } alu_fun_e;

  localparam logic [WIDTH-1:0] PLUS_EIGHT  = {{(WIDTH-4){1'b0}}, 4'b1000};
  localparam logic [WIDTH-1:0] MINUS_EIGHT = {{(WIDTH-4){1'b1}}, 4'b1000};
  localparam logic [3:0]       REG_NONE    = 4'hF;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_icode_q, out_icode_d;
  logic [WIDTH-1:0] out_valE_q,  out_valE_d;
  logic [WIDTH-1:0] out_valA_q,  out_valA_d;
  logic [3:0]       out_dstE_q,  out_dstE_d;
  logic             out_cnd_q,   out_cnd_d;
  logic [2:0]       cc_q,        cc_d;

  logic             xfer;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [3:0]       alu_fun;
  logic             alu_of;
  logic [2:0]       alu_cc;
  logic             cond;
  logic             zf, sf, of;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    alu_a = '0;
    unique case (icode)
      I_RRMOVQ, I_OPQ:            alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
      I_RET, I_POPQ:              alu_a = PLUS_EIGHT;
      I_CALL, I_PUSHQ:            alu_a = MINUS_EIGHT;
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (icode)
      I_IRMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
      default:                                                   alu_b = '0;
    endcase
  end

  assign alu_fun = (icode == I_OPQ) ? ifun : F_ADD;

  // Unknown OPq functions yield a zero result with the flags of zero.
  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    unique case (alu_fun)
      F_ADD: begin
        alu_r  = alu_b + alu_a;
        alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      F_SUB: begin
        alu_r  = alu_b - alu_a;
        alu_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      F_AND:   alu_r = alu_b & alu_a;
      F_XOR:   alu_r = alu_b ^ alu_a;
      default: alu_r = '0;
    endcase
  end

  assign alu_cc = {(alu_r == '0), alu_r[WIDTH-1], alu_of};

  assign {zf, sf, of} = cc_q;

  always_comb begin
    cond = 1'b0;
    unique case (ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = !zf;
      4'h5:    cond = !(sf ^ of);
      4'h6:    cond = !(sf ^ of) && !zf;
      default: cond = 1'b0;
    endcase
  end

  // NOTE: every next-state value defaults to the held value, so no path through this block can infer a latch.
  always_comb begin
    out_valid_d = out_valid_q;
    out_icode_d = out_icode_q;
    out_valE_d  = out_valE_q;
    out_valA_d  = out_valA_q;
    out_dstE_d  = out_dstE_q;
    out_cnd_d   = out_cnd_q;
    cc_d        = cc_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_icode_d = icode;
      out_valE_d  = alu_r;
      out_valA_d  = valA;
      out_dstE_d  = (icode == I_RRMOVQ && !cond) ? REG_NONE : dstE;
      out_cnd_d   = (icode == I_RRMOVQ || icode == I_JXX) ? cond : 1'b1;
      if (icode == I_OPQ && !m_stat_bad) cc_d = alu_cc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_icode_q <= 4'h0;
      out_valE_q  <= '0;
      out_valA_q  <= '0;
      out_dstE_q  <= REG_NONE;
      out_cnd_q   <= 1'b0;
      cc_q        <= CC_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_valE_q  <= out_valE_d;
      out_valA_q  <= out_valA_d;
      out_dstE_q  <= out_dstE_d;
      out_cnd_q   <= out_cnd_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_valE  = out_valE_q;
  assign out_valA  = out_valA_q;
  assign out_dstE  = out_dstE_q;
  assign out_cnd   = out_cnd_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed bench for exec_stage_pipe: a 64-bit instance for the main sequence
// and a 16-bit instance for the stack-pointer arithmetic cases.
module tb_exec_stage_pipe;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // 64-bit instance signals
  logic        rst, in_valid, in_ready, m_stat_bad, out_valid, out_ready, out_cnd;
  logic [3:0]  icode, ifun, dstE, out_icode, out_dstE;
  logic [63:0] valA, valB, valC, out_valE, out_valA;
  logic [2:0]  cc;

  // 16-bit instance signals
  logic        rst16, in_valid16, in_ready16, out_valid16, out_ready16, out_cnd16;
  logic [3:0]  icode16, ifun16, dstE16, out_icode16, out_dstE16;
  logic [15:0] valA16, valB16, valC16, out_valE16, out_valA16;
  logic [2:0]  cc16;

  exec_stage_pipe #(.WIDTH(64), .CC_RST(3'b100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .m_stat_bad(m_stat_bad), .out_valid(out_valid),
    .out_ready(out_ready), .out_icode(out_icode), .out_valE(out_valE),
    .out_valA(out_valA), .out_dstE(out_dstE), .out_cnd(out_cnd), .cc(cc)
  );

  exec_stage_pipe #(.WIDTH(16), .CC_RST(3'b100)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .icode(icode16), .ifun(ifun16), .valA(valA16), .valB(valB16), .valC(valC16),
    .dstE(dstE16), .m_stat_bad(1'b0), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_icode(out_icode16), .out_valE(out_valE16),
    .out_valA(out_valA16), .out_dstE(out_dstE16), .out_cnd(out_cnd16), .cc(cc16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] d);
    in_valid = 1'b1;
    icode    = ic;
    ifun     = fn;
    valA     = a;
    valB     = b;
    valC     = 64'h100;
    dstE     = d;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; m_stat_bad = 1'b0;
    icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0; dstE = 4'h0;
    rst16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b1;
    icode16 = 4'h0; ifun16 = 4'h0; valA16 = '0; valB16 = '0; valC16 = '0; dstE16 = 4'h0;

    // Reset for two cycles
    tick(); tick();
    check("rst_cc",        64'(cc), 64'h4);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_dstE",  64'(out_dstE), 64'hF);
    check("rst_in_ready",  64'(in_ready), 64'h1);
    rst = 1'b0;

    // addq 5 + 7
    present(4'h6, 4'h0, 64'd5, 64'd7, 4'h2);
    tick();
    check("addq_valE",  out_valE, 64'd12);
    check("addq_cc",    64'(cc), 64'h0);
    check("addq_valid", 64'(out_valid), 64'h1);
    check("addq_dstE",  64'(out_dstE), 64'h2);

    // subq equal operands -> zero
    present(4'h6, 4'h1, 64'h1234, 64'h1234, 4'h2);
    tick();
    check("subq_zero_valE", out_valE, 64'h0);
    check("subq_zero_cc",   64'(cc), 64'h4);

    // je right after subq sees ZF=1
    present(4'h7, 4'h3, 64'h0, 64'h0, 4'hF);
    tick();
    check("je_cnd",   64'(out_cnd), 64'h1);
    check("je_icode", 64'(out_icode), 64'h7);
    check("je_cc",    64'(cc), 64'h4);

    // jne
    present(4'h7, 4'h4, 64'h0, 64'h0, 4'hF);
    tick();
    check("jne_cnd", 64'(out_cnd), 64'h0);

    // addq signed overflow
    present(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1);
    tick();
    check("addq_ovf_valE", out_valE, 64'h8000_0000_0000_0000);
    check("addq_ovf_cc",   64'(cc), 64'h3);

    // cmovl with SF^OF = 0 -> not taken
    present(4'h2, 4'h2, 64'h55, 64'h0, 4'h3);
    tick();
    check("cmovl_cnd",  64'(out_cnd), 64'h0);
    check("cmovl_dstE", 64'(out_dstE), 64'hF);
    check("cmovl_valE", out_valE, 64'h55);
    check("cmovl_valA", out_valA, 64'h55);

    // Backpressure: subq 0 - 1 held off for three cycles
    out_ready = 1'b0;
    present(4'h6, 4'h1, 64'd1, 64'd0, 4'h4);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready_hold", 64'(in_ready), 64'h0);
      check("stall_valid",         64'(out_valid), 64'h1);
      check("stall_valE",          out_valE, 64'h55);
      check("stall_dstE",          64'(out_dstE), 64'hF);
      check("stall_cc",            64'(cc), 64'h3);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("subq_neg_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    check("subq_neg_cc",   64'(cc), 64'h2);
    check("subq_neg_dstE", 64'(out_dstE), 64'h4);

    // addq while a later stage faults: result computed, CC untouched
    m_stat_bad = 1'b1;
    present(4'h6, 4'h0, 64'd2, 64'd3, 4'h5);
    tick();
    check("fault_valE", out_valE, 64'd5);
    check("fault_cc",   64'(cc), 64'h2);
    m_stat_bad = 1'b0;

    // Stall, then reset mid-stall
    out_ready = 1'b0;
    present(4'h6, 4'h0, 64'd0, 64'd0, 4'h6);
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    check("pre_rst_valE",  out_valE, 64'd5);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_cc",    64'(cc), 64'h4);
    check("mid_rst_valE",  out_valE, 64'h0);
    check("mid_rst_dstE",  64'(out_dstE), 64'hF);
    check("mid_rst_cnd",   64'(out_cnd), 64'h0);
    check("mid_rst_icode", 64'(out_icode), 64'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // addq 3 + 4 followed by a bubble
    present(4'h6, 4'h0, 64'd3, 64'd4, 4'h7);
    tick();
    check("addq2_valE", out_valE, 64'd7);
    check("addq2_cc",   64'(cc), 64'h0);
    in_valid = 1'b0;
    tick();
    check("bubble_valid", 64'(out_valid), 64'h0);
    check("bubble_valE",  out_valE, 64'd7);

    // OPq with unsupported function -> zero result, flags of zero
    present(4'h6, 4'h7, 64'd1, 64'd2, 4'h8);
    tick();
    check("badfun_valE", out_valE, 64'h0);
    check("badfun_cc",   64'(cc), 64'h4);
    check("badfun_cnd",  64'(out_cnd), 64'h1);
    in_valid = 1'b0;

    // 16-bit instance: stack pointer arithmetic
    tick();
    rst16 = 1'b0;
    in_valid16 = 1'b1; icode16 = 4'hA; ifun16 = 4'h0; valB16 = 16'h0010; dstE16 = 4'h4;
    tick();
    check("w16_pushq_valE", 64'(out_valE16), 64'h0008);
    check("w16_pushq_cc",   64'(cc16), 64'h4);
    icode16 = 4'hB; valB16 = 16'hFFFC;
    tick();
    check("w16_popq_valE", 64'(out_valE16), 64'h0004);
    check("w16_popq_cc",   64'(cc16), 64'h4);
    in_valid16 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
